search_stage_gn: RTL and testbench

Parametrised search pipeline stage for the grouped packet classifier: G_NUM independent group tables are searched in parallel at one stage of the chain, with each group's match result merged with the upstream stage's result. Compared with the fixed six-group stage, it adds a valid qualifier, a runtime table-update write port, aligned 2-cycle latency and per-group saturating hit counters. Instances are chained back-to-back; out_* of stage k feeds last_*/search_* of stage k+1.

---
 rtl/search_pkg.sv | 48 ++++
 rtl/search_group_table.sv | 77 +++++++
 rtl/search_stage_gn.sv | 155 +++++++++++++++
 tb/tb_search_stage_gn.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/search_pkg.sv
// search_pkg: shared definitions for the grouped classifier search stage.
// Holds the entry layout {valid, ruleID, next_index, key, mask} (MSB first),
// expressed as offset functions of the index and tuple widths, together with
// the field-extraction and masked tuple-match helpers. Fields are handled in
// a fixed wide container so that one set of functions serves every
// parameterisation; callers narrow the results with size casts.
package search_pkg;

    // Wide enough for any entry width the stage is expected to be built with.
    localparam int FIELD_MAX = 512;
    typedef logic [FIELD_MAX-1:0] wide_t;

    // The mask field occupies the least significant bits of an entry.
    localparam int MASK_LSB = 0;

    function automatic int key_lsb(input int pkt_len);
        return pkt_len;
    endfunction

    function automatic int next_lsb(input int pkt_len);
        return 32'sd2 * pkt_len;
    endfunction

    function automatic int rule_lsb(input int idx_len, input int pkt_len);
        return 32'sd2 * pkt_len + idx_len;
    endfunction

    function automatic int valid_lsb(input int idx_len, input int pkt_len);
        return 32'sd2 * pkt_len + 32'sd2 * idx_len;
    endfunction

    function automatic int entry_len(input int idx_len, input int pkt_len);
        return 32'sd1 + 32'sd2 * idx_len + 32'sd2 * pkt_len;
    endfunction

    // Extract 'width' bits starting at 'lsb', zero-extended to the container.
    function automatic wide_t get_field(input wide_t entry, input int lsb, input int width);
        wide_t sel_mask;
        sel_mask = ~({FIELD_MAX{1'b1}} << width);
        return (entry >> lsb) & sel_mask;
    endfunction

    // A tuple matches when every bit selected by the mask equals the key.
    function automatic logic tuple_match(input wide_t tuple, input wide_t key, input wide_t mask);
        return ((tuple ^ key) & mask) == {FIELD_MAX{1'b0}};
    endfunction

endpackage

// File: rtl/search_group_table.sv
// search_group_table: one group's rule table plus its match compare.
// TABLE_DEPTH x ENTRY_BIT_LEN synchronous RAM, one write port and one
// read-first read port. The registered read entry is compared against the
// (already registered) tuple in the following cycle.
// Ports:
//   clk         rising-edge clock
//   wr_en       write strobe for this group (group select done by the caller)
//   wr_addr     entry to write; addresses >= TABLE_DEPTH are ignored
//   wr_data     entry {valid, ruleID, next_index, key, mask}
//   rd_addr     search index, read at this clock edge
//   tuple       search key aligned with the registered read data
//   hit         entry valid and masked key equal
//   rule_id     ruleID field of the read entry
//   next_index  next_index field of the read entry
module search_group_table
    import search_pkg::*;
#(
    parameter int INDEX_BIT_LEN  = 11,
    parameter int PACKET_BIT_LEN = 104,
    parameter int TABLE_DEPTH    = 2048,
    localparam int ENTRY_BIT_LEN = entry_len(INDEX_BIT_LEN, PACKET_BIT_LEN)
)(
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [INDEX_BIT_LEN-1:0]  wr_addr,
    input  logic [ENTRY_BIT_LEN-1:0]  wr_data,
    input  logic [INDEX_BIT_LEN-1:0]  rd_addr,
    input  logic [PACKET_BIT_LEN-1:0] tuple,
    output logic                      hit,
    output logic [INDEX_BIT_LEN-1:0]  rule_id,
    output logic [INDEX_BIT_LEN-1:0]  next_index
);

    localparam int ADDR_BIT_LEN = $clog2(TABLE_DEPTH);
    localparam logic [INDEX_BIT_LEN:0] DEPTH_C = (INDEX_BIT_LEN + 1)'(TABLE_DEPTH);

    logic [ENTRY_BIT_LEN-1:0] mem_r [TABLE_DEPTH];
    logic [ENTRY_BIT_LEN-1:0] rd_r;
    logic                     wr_ok_s;
    logic                     rd_ok_s;
    wide_t                    entry_w_s;
    wide_t                    tuple_w_s;

    // Address range qualification for both ports.
    always_comb begin
        wr_ok_s = ({1'b0, wr_addr} < DEPTH_C);
        rd_ok_s = ({1'b0, rd_addr} < DEPTH_C);
    end

    // Table storage: contents are deliberately not reset; the read register
    // samples the pre-write value so a same-address write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok_s) begin
            mem_r[wr_addr[ADDR_BIT_LEN-1:0]] <= wr_data;
        end
        if (rd_ok_s) begin
            rd_r <= mem_r[rd_addr[ADDR_BIT_LEN-1:0]];
        end else begin
            rd_r <= {ENTRY_BIT_LEN{1'b0}};
        end
    end

    // Field decode and masked compare of the registered entry.
    always_comb begin
        entry_w_s  = wide_t'(rd_r);
        tuple_w_s  = wide_t'(tuple);
        hit        = (get_field(entry_w_s, valid_lsb(INDEX_BIT_LEN, PACKET_BIT_LEN), 1)
                      != {FIELD_MAX{1'b0}})
                     && tuple_match(tuple_w_s,
                                    get_field(entry_w_s, key_lsb(PACKET_BIT_LEN), PACKET_BIT_LEN),
                                    get_field(entry_w_s, MASK_LSB, PACKET_BIT_LEN));
        rule_id    = INDEX_BIT_LEN'(get_field(entry_w_s, rule_lsb(INDEX_BIT_LEN, PACKET_BIT_LEN),
                                              INDEX_BIT_LEN));
        next_index = INDEX_BIT_LEN'(get_field(entry_w_s, next_lsb(PACKET_BIT_LEN), INDEX_BIT_LEN));
    end

endmodule

// File: rtl/search_stage_gn.sv
// search_stage_gn: one stage of the grouped classifier search chain.
// G_NUM group tables are searched in parallel; each group's hit is merged
// with the upstream result (an upstream match is sticky and wins). Latency
// is 2 cycles from in_valid to out_valid, one search per cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          qualifies tupleData, search_index and last_*
//   tupleData         search key
//   search_index      per-group read index, group g at slice g
//   last_match/ruleID upstream merged result
//   wr_en/group/addr/data  runtime table write port
//   cnt_clear         synchronous clear of all hit counters (wins over increment)
//   out_valid/match/ruleID/next_index  registered merged result, zero when idle
//   hit_cnt           per-group saturating counters of fresh (non-upstream) hits
module search_stage_gn
    import search_pkg::*;
#(
    parameter int G_NUM          = 6,
    parameter int INDEX_BIT_LEN  = 11,
    parameter int PACKET_BIT_LEN = 104,
    parameter int TABLE_DEPTH    = 2048,
    parameter int CNT_BIT_LEN    = 16,
    localparam int ENTRY_BIT_LEN = entry_len(INDEX_BIT_LEN, PACKET_BIT_LEN),
    localparam int GRP_BIT_LEN   = $clog2(G_NUM)
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [PACKET_BIT_LEN-1:0]        tupleData,
    input  logic [G_NUM*INDEX_BIT_LEN-1:0]   search_index,
    input  logic [G_NUM-1:0]                 last_match,
    input  logic [G_NUM*INDEX_BIT_LEN-1:0]   last_ruleID,
    input  logic                             wr_en,
    input  logic [GRP_BIT_LEN-1:0]           wr_group,
    input  logic [INDEX_BIT_LEN-1:0]         wr_addr,
    input  logic [ENTRY_BIT_LEN-1:0]         wr_data,
    input  logic                             cnt_clear,
    output logic                             out_valid,
    output logic [G_NUM-1:0]                 out_match,
    output logic [G_NUM*INDEX_BIT_LEN-1:0]   out_ruleID,
    output logic [G_NUM*INDEX_BIT_LEN-1:0]   out_next_index,
    output logic [G_NUM*CNT_BIT_LEN-1:0]     hit_cnt
);

    localparam int IL = INDEX_BIT_LEN;
    localparam int CL = CNT_BIT_LEN;

    logic                      vld_r;
    logic [PACKET_BIT_LEN-1:0] tuple_r;
    logic [G_NUM-1:0]          last_match_r;
    logic [G_NUM*IL-1:0]       last_rule_r;

    logic [G_NUM-1:0]          wr_sel_s;
    logic [G_NUM-1:0]          tbl_hit_s;
    logic [G_NUM*IL-1:0]       tbl_rule_s;
    logic [G_NUM*IL-1:0]       tbl_next_s;

    logic [G_NUM-1:0]          match_nxt_s;
    logic [G_NUM*IL-1:0]       rule_nxt_s;
    logic [G_NUM*IL-1:0]       next_nxt_s;
    logic [G_NUM*CL-1:0]       cnt_nxt_s;

    // Per-group write select; group numbers >= G_NUM select nothing.
    always_comb begin
        wr_sel_s = {G_NUM{1'b0}};
        for (int g = 0; g < G_NUM; g++) begin
            wr_sel_s[g] = wr_en && (wr_group == GRP_BIT_LEN'(g));
        end
    end

    for (genvar g = 0; g < G_NUM; g++) begin : g_tbl
        search_group_table #(
            .INDEX_BIT_LEN  (INDEX_BIT_LEN),
            .PACKET_BIT_LEN (PACKET_BIT_LEN),
            .TABLE_DEPTH    (TABLE_DEPTH)
        ) u_tbl (
            .clk        (clk),
            .wr_en      (wr_sel_s[g]),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .rd_addr    (search_index[g*IL +: IL]),
            .tuple      (tuple_r),
            .hit        (tbl_hit_s[g]),
            .rule_id    (tbl_rule_s[g*IL +: IL]),
            .next_index (tbl_next_s[g*IL +: IL])
        );
    end

    // Stage-0 registers: keep search side data aligned with the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r        <= 1'b0;
            tuple_r      <= {PACKET_BIT_LEN{1'b0}};
            last_match_r <= {G_NUM{1'b0}};
            last_rule_r  <= {(G_NUM*IL){1'b0}};
        end else begin
            vld_r        <= in_valid;
            tuple_r      <= tupleData;
            last_match_r <= last_match;
            last_rule_r  <= last_ruleID;
        end
    end

    // Merge with upstream result and compute next counter values.
    always_comb begin
        match_nxt_s = {G_NUM{1'b0}};
        rule_nxt_s  = {(G_NUM*IL){1'b0}};
        next_nxt_s  = {(G_NUM*IL){1'b0}};
        cnt_nxt_s   = hit_cnt;
        for (int g = 0; g < G_NUM; g++) begin
            if (vld_r) begin
                if (last_match_r[g]) begin
                    match_nxt_s[g]         = 1'b1;
                    rule_nxt_s[g*IL +: IL] = last_rule_r[g*IL +: IL];
                end else if (tbl_hit_s[g]) begin
                    match_nxt_s[g]         = 1'b1;
                    rule_nxt_s[g*IL +: IL] = tbl_rule_s[g*IL +: IL];
                end else begin
                    match_nxt_s[g]         = 1'b0;
                    rule_nxt_s[g*IL +: IL] = {IL{1'b0}};
                end
                next_nxt_s[g*IL +: IL] = tbl_next_s[g*IL +: IL];
            end else begin
                next_nxt_s[g*IL +: IL] = {IL{1'b0}};
            end

            // Only hits found by this stage count; the counter sticks at all-ones.
            if (cnt_clear) begin
                cnt_nxt_s[g*CL +: CL] = {CL{1'b0}};
            end else if (vld_r && !last_match_r[g] && tbl_hit_s[g] && !(&hit_cnt[g*CL +: CL])) begin
                cnt_nxt_s[g*CL +: CL] = hit_cnt[g*CL +: CL] + CL'(1'b1);
            end else begin
                cnt_nxt_s[g*CL +: CL] = hit_cnt[g*CL +: CL];
            end
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_match      <= {G_NUM{1'b0}};
            out_ruleID     <= {(G_NUM*IL){1'b0}};
            out_next_index <= {(G_NUM*IL){1'b0}};
            hit_cnt        <= {(G_NUM*CL){1'b0}};
        end else begin
            out_valid      <= vld_r;
            out_match      <= match_nxt_s;
            out_ruleID     <= rule_nxt_s;
            out_next_index <= next_nxt_s;
            hit_cnt        <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_search_stage_gn.sv
// Testbench for search_stage_gn: directed searches with hand-computed
// expected results pushed into a scoreboard queue and checked by a separate
// monitor whenever out_valid is seen. A second instance with 2-bit counters
// and a 16-entry table shares all inputs to cover saturation and
// out-of-range writes.
module tb_search_stage_gn;

    localparam logic [103:0] K    = 104'h0A0B0C0D_11223344_1F90_0050_06;
    localparam logic [103:0] ONES = {104{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [103:0]  tupleData = 104'd0;
    logic [65:0]   search_index = 66'd0;
    logic [5:0]    last_match = 6'd0;
    logic [65:0]   last_ruleID = 66'd0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_group = 3'd0;
    logic [10:0]   wr_addr = 11'd0;
    logic [230:0]  wr_data = 231'd0;
    logic          cnt_clear = 1'b0;

    logic          out_valid, out_valid_s;
    logic [5:0]    out_match, out_match_s;
    logic [65:0]   out_ruleID, out_ruleID_s;
    logic [65:0]   out_next_index, out_next_index_s;
    logic [95:0]   hit_cnt;
    logic [11:0]   hit_cnt_s;

    typedef struct {
        logic [5:0]  m;
        logic [65:0] r;
        logic [65:0] n;
        logic [95:0] c;
        logic [11:0] cs;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt [6];
    logic [1:0]  exp_cnt_s [6];

    search_stage_gn dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .tupleData(tupleData),
        .search_index(search_index), .last_match(last_match), .last_ruleID(last_ruleID),
        .wr_en(wr_en), .wr_group(wr_group), .wr_addr(wr_addr), .wr_data(wr_data),
        .cnt_clear(cnt_clear), .out_valid(out_valid), .out_match(out_match),
        .out_ruleID(out_ruleID), .out_next_index(out_next_index), .hit_cnt(hit_cnt)
    );

    search_stage_gn #(.CNT_BIT_LEN(2), .TABLE_DEPTH(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .tupleData(tupleData),
        .search_index(search_index), .last_match(last_match), .last_ruleID(last_ruleID),
        .wr_en(wr_en), .wr_group(wr_group), .wr_addr(wr_addr), .wr_data(wr_data),
        .cnt_clear(cnt_clear), .out_valid(out_valid_s), .out_match(out_match_s),
        .out_ruleID(out_ruleID_s), .out_next_index(out_next_index_s), .hit_cnt(hit_cnt_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [65:0] f11(input int g, input logic [10:0] v);
        logic [65:0] r;
        r = 66'd0;
        r[g*11 +: 11] = v;
        return r;
    endfunction

    function automatic logic [230:0] mk(input logic v, input logic [10:0] rule,
                                       input logic [10:0] nxt, input logic [103:0] key,
                                       input logic [103:0] mask);
        return {v, rule, nxt, key, mask};
    endfunction

    task automatic wr(input logic [2:0] g, input logic [10:0] a, input logic [230:0] d);
        wr_en = 1'b1; wr_group = g; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Issue one search and queue its expected result (counters from exp_cnt*).
    task automatic search(input logic [65:0] idx, input logic [103:0] tup,
                          input logic [5:0] lm, input logic [65:0] lr,
                          input logic [5:0] em, input logic [65:0] erule,
                          input logic [65:0] enext);
        exp_t e;
        in_valid = 1'b1; search_index = idx; tupleData = tup;
        last_match = lm; last_ruleID = lr;
        e.m = em; e.r = erule; e.n = enext; e.cyc = cyc + 2;
        for (int g = 0; g < 6; g++) begin
            e.c[g*16 +: 16] = exp_cnt[g];
            e.cs[g*2 +: 2]  = exp_cnt_s[g];
        end
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; wr_en = 1'b0; last_match = 6'd0; last_ruleID = 66'd0;
    endtask

    // Monitor: pops and compares on every out_valid; idle outputs must be zero.
    always @(negedge clk) begin
        chk("valid_pair", 128'(out_valid_s), 128'(out_valid));
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 128'(out_valid), 128'(1'b0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("latency", 128'(cyc), 128'(mon_e.cyc));
                chk("out_match", 128'(out_match), 128'(mon_e.m));
                chk("out_ruleID", 128'(out_ruleID), 128'(mon_e.r));
                chk("out_next_index", 128'(out_next_index), 128'(mon_e.n));
                chk("hit_cnt", 128'(hit_cnt), 128'(mon_e.c));
                chk("hit_cnt_small", 128'(hit_cnt_s), 128'(mon_e.cs));
            end
        end else begin
            chk("idle_match", 128'(out_match), 128'd0);
            chk("idle_ruleID", 128'(out_ruleID), 128'd0);
            chk("idle_next", 128'(out_next_index), 128'd0);
        end
    end

    initial begin
        for (int g = 0; g < 6; g++) begin
            exp_cnt[g] = 16'd0;
            exp_cnt_s[g] = 2'd0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid", 128'(out_valid), 128'd0);
        chk("reset_cnt", 128'(hit_cnt), 128'd0);
        chk("reset_cnt_small", 128'(hit_cnt_s), 128'd0);

        // Clear every entry of every table (small instance ignores addr >= 16).
        for (int g = 0; g < 6; g++) begin
            for (int a = 0; a < 2048; a++) begin
                wr(3'(g), 11'(a), 231'd0);
            end
        end

        // Empty tables: no match anywhere.
        search(66'd0, K, 6'd0, 66'd0, 6'd0, 66'd0, 66'd0);

        // Exact-key hit in group 2, then a one-bit miss.
        wr(3'd2, 11'd5, mk(1'b1, 11'h123, 11'h040, K, ONES));
        exp_cnt[2] = 16'd1; exp_cnt_s[2] = 2'd1;
        search(f11(2, 11'd5), K, 6'd0, 66'd0, 6'b000100, f11(2, 11'h123), f11(2, 11'h040));
        search(f11(2, 11'd5), K ^ 104'd1, 6'd0, 66'd0, 6'd0, 66'd0, f11(2, 11'h040));

        // Upstream wins over a table hit (group 0) and over no hit (group 5).
        wr(3'd0, 11'd3, mk(1'b1, 11'h010, 11'h001, K, ONES));
        search(f11(0, 11'd3), K, 6'b100001, f11(0, 11'h7FF) | f11(5, 11'h2AA),
               6'b100001, f11(0, 11'h7FF) | f11(5, 11'h2AA), f11(0, 11'h001));
        exp_cnt[0] = 16'd1; exp_cnt_s[0] = 2'd1;
        search(f11(0, 11'd3), K, 6'd0, 66'd0, 6'b000001, f11(0, 11'h010), f11(0, 11'h001));

        // Masked compare: low byte is don't-care, bit 8 is not.
        wr(3'd1, 11'd7, mk(1'b1, 11'h055, 11'h100, K, ~104'hFF));
        exp_cnt[1] = 16'd1; exp_cnt_s[1] = 2'd1;
        search(f11(1, 11'd7), K ^ 104'h5A, 6'd0, 66'd0, 6'b000010, f11(1, 11'h055), f11(1, 11'h100));
        search(f11(1, 11'd7), K ^ 104'h100, 6'd0, 66'd0, 6'd0, 66'd0, f11(1, 11'h100));

        // Entry with valid = 0 never hits but still supplies next_index.
        wr(3'd3, 11'd9, mk(1'b0, 11'h077, 11'h0AA, K, ONES));
        search(f11(3, 11'd9), K, 6'd0, 66'd0, 6'd0, 66'd0, f11(3, 11'h0AA));

        // Write to a non-existent group is ignored.
        wr(3'd7, 11'd0, mk(1'b1, 11'h3FF, 11'h3FF, K, ONES));
        search(66'd0, K, 6'd0, 66'd0, 6'd0, 66'd0, 66'd0);

        // Address 20 is beyond the small table: only the large instance hits.
        wr(3'd5, 11'd20, mk(1'b1, 11'h0C3, 11'h0C4, K, ONES));
        exp_cnt[5] = 16'd1;
        search(f11(5, 11'd20), K, 6'd0, 66'd0, 6'b100000, f11(5, 11'h0C3), f11(5, 11'h0C4));

        // Same-cycle write and search return the old entry; next cycle the new one.
        wr(3'd4, 11'd11, mk(1'b1, 11'h021, 11'h011, K, ONES));
        wr_en = 1'b1; wr_group = 3'd4; wr_addr = 11'd11;
        wr_data = mk(1'b1, 11'h022, 11'h012, K, ONES);
        exp_cnt[4] = 16'd1; exp_cnt_s[4] = 2'd1;
        search(f11(4, 11'd11), K, 6'd0, 66'd0, 6'b010000, f11(4, 11'h021), f11(4, 11'h011));
        exp_cnt[4] = 16'd2; exp_cnt_s[4] = 2'd2;
        search(f11(4, 11'd11), K, 6'd0, 66'd0, 6'b010000, f11(4, 11'h022), f11(4, 11'h012));

        // Five back-to-back fresh hits on group 2: 2-bit counter holds at 3.
        for (int i = 0; i < 5; i++) begin
            exp_cnt[2] = 16'(2 + i);
            exp_cnt_s[2] = (i == 0) ? 2'd2 : 2'd3;
            search(f11(2, 11'd5), K, 6'd0, 66'd0, 6'b000100, f11(2, 11'h123), f11(2, 11'h040));
        end

        // Clear coincident with a fresh hit: all counters read zero.
        for (int g = 0; g < 6; g++) begin
            exp_cnt[g] = 16'd0;
            exp_cnt_s[g] = 2'd0;
        end
        search(f11(2, 11'd5), K, 6'd0, 66'd0, 6'b000100, f11(2, 11'h123), f11(2, 11'h040));
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        exp_cnt[2] = 16'd1; exp_cnt_s[2] = 2'd1;
        search(f11(2, 11'd5), K, 6'd0, 66'd0, 6'b000100, f11(2, 11'h123), f11(2, 11'h040));
        repeat (3) @(posedge clk);
        #1;

        // Reset with two searches in flight: both must be dropped.
        in_valid = 1'b1; search_index = f11(2, 11'd5); tupleData = K;
        @(posedge clk); #1;
        search_index = f11(0, 11'd3);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; search_index = 66'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_cnt", 128'(hit_cnt), 128'd0);
        chk("post_reset_cnt_small", 128'(hit_cnt_s), 128'd0);
        for (int g = 0; g < 6; g++) begin
            exp_cnt[g] = 16'd0;
            exp_cnt_s[g] = 2'd0;
        end
        exp_cnt[2] = 16'd1; exp_cnt_s[2] = 2'd1;
        search(f11(2, 11'd5), K, 6'd0, 66'd0, 6'b000100, f11(2, 11'h123), f11(2, 11'h040));

        // Bounded drain of the scoreboard.
        repeat (5) @(posedge clk);
        #1;
        chk("drain", 128'(sb_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
